// File: rtl/kt_pkg.sv
// Shared definitions for the alarm sequencer slice.
// Holds the alarm FSM state encodings, the LED bank patterns and a helper
// that sizes counters so that a parameter value of 1 still gets a 1-bit
// register.
package kt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_QUIET = 2'd2
  } state_e;

  localparam logic [9:0] LED_ALL_ON  = 10'h3FF;
  localparam logic [9:0] LED_ALL_OFF = 10'h000;

  // $clog2(1) is 0, which cannot size a vector, so clamp to one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-clock tick every TICK_DIV clocks.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   tick  - high for exactly one clk while the count sits at TICK_DIV-1
module tick_gen
  import kt_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // With TICK_DIV=1 the count is pinned at 0 and tick stays high every clk.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_seq.sv
// Countdown-timer alarm sequencer: once the countdown has been run and
// reaches 00:00 it blinks the LED bank and drives a 500 Hz piezo tone,
// falls back to a steady, silent LED bank after TIMEOUT_MS ticks, and
// returns to idle on an acknowledge press or when the display leaves 00:00.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   zero    - countdown digits read 00:00
//   running - countdown enabled; arms the alarm
//   ack     - debounced acknowledge button level
//   led     - registered alarm LED bank
//   buzz    - registered piezo drive
//   active  - state is not IDLE
module alarm_seq
  import kt_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int BLINK_MS   = 250,
  parameter int TIMEOUT_MS = 30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zero,
  input  logic       running,
  input  logic       ack,
  output logic [9:0] led,
  output logic       buzz,
  output logic       active
);

  localparam int BW = cnt_width(BLINK_MS);
  localparam int TW = cnt_width(TIMEOUT_MS);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_MS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_MS - 1);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic          zero_prev_q, zero_prev_d;
  logic          ack_prev_q, ack_prev_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          phase_q, phase_d;
  logic          tone_q, tone_d;
  logic [9:0]    led_q, led_d;
  logic          buzz_q, buzz_d;
  logic          start;
  logic          ack_edge;

  // Next-state logic. The alarm only fires on a fresh 00:00 edge after the
  // countdown has actually run, so a display already at 00:00 when reset
  // releases never sounds. Leaving ALARM/QUIET on ack or zero-low is checked
  // before the timeout so a same-cycle acknowledge always wins.
  always_comb begin
    start       = zero & ~zero_prev_q & armed_q;
    ack_edge    = ack & ~ack_prev_q;
    state_d     = state_q;
    armed_d     = armed_q | running;
    zero_prev_d = zero;
    ack_prev_d  = ack;
    blink_d     = blink_q;
    timeout_d   = timeout_q;
    phase_d     = phase_q;
    tone_d      = tone_q;

    case (state_q)
      ST_IDLE: begin
        blink_d   = '0;
        timeout_d = '0;
        phase_d   = 1'b0;
        tone_d    = 1'b0;
        if (start) begin
          state_d = ST_ALARM;
          phase_d = 1'b1;
          armed_d = 1'b0;
        end
      end
      ST_ALARM: begin
        if (ack_edge || !zero) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          tone_d = ~tone_q;
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
          if (timeout_q == TIMEOUT_LAST) begin
            state_d = ST_QUIET;
          end else begin
            timeout_d = timeout_q + TW'(1);
          end
        end
      end
      ST_QUIET: begin
        if (ack_edge || !zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current registered state, so led/buzz settle one
  // clk after the state or phase changes and never glitch.
  always_comb begin
    led_d  = LED_ALL_OFF;
    buzz_d = 1'b0;
    case (state_q)
      ST_ALARM: begin
        led_d  = phase_q ? LED_ALL_ON : LED_ALL_OFF;
        buzz_d = phase_q & tone_q;
      end
      ST_QUIET: begin
        led_d = LED_ALL_ON;
      end
      default: begin
        led_d  = LED_ALL_OFF;
        buzz_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      zero_prev_q <= 1'b0;
      ack_prev_q  <= 1'b0;
      blink_q     <= '0;
      timeout_q   <= '0;
      phase_q     <= 1'b0;
      tone_q      <= 1'b0;
      led_q       <= LED_ALL_OFF;
      buzz_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      zero_prev_q <= zero_prev_d;
      ack_prev_q  <= ack_prev_d;
      blink_q     <= blink_d;
      timeout_q   <= timeout_d;
      phase_q     <= phase_d;
      tone_q      <= tone_d;
      led_q       <= led_d;
      buzz_q      <= buzz_d;
    end
  end

  assign led    = led_q;
  assign buzz   = buzz_q;
  assign active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alarm_seq.sv
// Self-checking bench for alarm_seq with small parameters. A behavioural
// model, written in terms of ticks elapsed since alarm entry, pushes the
// expected {led, buzz, active} for every driven cycle into a scoreboard
// queue; each scenario task pops and compares after the clock edge.
module tb_alarm_seq;

  localparam int TD = 4;
  localparam int BL = 3;
  localparam int TO = 20;

  logic       clk;
  logic       reset;
  logic       zero;
  logic       running;
  logic       ack;
  logic [9:0] led;
  logic       buzz;
  logic       active;

  int checks   = 0;
  int failures = 0;

  logic [11:0] sb_q[$];

  int m_state;
  int m_div;
  int m_ticks;
  bit m_armed;
  bit m_zprev;
  bit m_aprev;

  alarm_seq #(
    .TICK_DIV  (TD),
    .BLINK_MS  (BL),
    .TIMEOUT_MS(TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .zero   (zero),
    .running(running),
    .ack    (ack),
    .led    (led),
    .buzz   (buzz),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    m_state = 0;
    m_div   = 0;
    m_ticks = 0;
    m_armed = 1'b0;
    m_zprev = 1'b0;
    m_aprev = 1'b0;
    sb_q.delete();
  endfunction

  // Model of one clock edge. Blink phase and tone are derived from the
  // number of ticks since entry rather than from separate counters.
  function automatic void model_step(input bit z, input bit r, input bit a);
    bit         tk;
    bit         ph;
    bit         tn;
    bit         a_edge;
    bit         st;
    logic [9:0] e_led;
    bit         e_buzz;
    int         ns;
    tk     = (m_div == TD - 1);
    ph     = ((m_ticks / BL) % 2) == 0;
    tn     = (m_ticks % 2) == 1;
    e_led  = (m_state == 2) ? 10'h3FF : ((m_state == 1 && ph) ? 10'h3FF : 10'h000);
    e_buzz = (m_state == 1) && ph && tn;
    a_edge = a && !m_aprev;
    st     = z && !m_zprev && m_armed;
    ns     = m_state;
    if (m_state == 0) begin
      if (st) begin
        ns      = 1;
        m_ticks = 0;
      end
    end else if (a_edge || !z) begin
      ns = 0;
    end else if (m_state == 1 && tk) begin
      if (m_ticks == TO - 1) ns = 2;
      else m_ticks = m_ticks + 1;
    end
    m_armed = (m_state == 0 && ns == 1) ? 1'b0 : (m_armed || r);
    m_zprev = z;
    m_aprev = a;
    m_div   = (m_div + 1) % TD;
    m_state = ns;
    sb_q.push_back({e_led, e_buzz, (ns != 0)});
  endfunction

  task automatic advance(input bit z, input bit r, input bit a);
    zero    = z;
    running = r;
    ack     = a;
    model_step(z, r, a);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    zero    = 1'b0;
    running = 1'b0;
    ack     = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if (led !== 10'h000) begin
      failures++;
      $display("[TB] FAIL reset_led got=%h want=000", led);
    end
    checks++;
    if (buzz !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_buzz got=%b want=0", buzz);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_active got=%b want=0", active);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_no_arm();
    logic [11:0] exp;
    for (int i = 0; i < 14; i++) begin
      advance((i >= 3), 1'b0, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL no_arm cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    advance(1'b0, 1'b0, 1'b0);
    void'(sb_q.pop_front());
  endtask

  task automatic test_alarm_blink();
    logic [11:0] exp;
    logic [9:0]  prev_led;
    int          last_change;
    int          changes;
    last_change = -1;
    changes     = 0;
    for (int i = 0; i < 2; i++) begin
      advance(1'b0, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL blink_arm cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    prev_led = led;
    for (int i = 0; i < 40; i++) begin
      advance(1'b1, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL blink cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
      if (i == 0) begin
        checks++;
        if (active !== 1'b1) begin
          failures++;
          $display("[TB] FAIL blink_entry_active got=%b want=1", active);
        end
      end
      if (led !== prev_led) begin
        if (changes >= 2) begin
          checks++;
          if (i - last_change != 12) begin
            failures++;
            $display("[TB] FAIL blink_period got=%0d want=12", i - last_change);
          end
        end
        last_change = i;
        changes++;
      end
      prev_led = led;
    end
    checks++;
    if (changes < 4) begin
      failures++;
      $display("[TB] FAIL blink_toggles got=%0d want>=4", changes);
    end
    for (int i = 0; i < 2; i++) begin
      advance(1'b0, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL zero_drop cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    checks++;
    if (led !== 10'h000 || active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_drop_idle got led=%h active=%b want led=000 active=0", led, active);
    end
  endtask

  task automatic test_timeout_quiet();
    logic [11:0] exp;
    for (int i = 0; i < 92; i++) begin
      advance((i != 0), 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL timeout cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    checks++;
    if (led !== 10'h3FF || buzz !== 1'b0 || active !== 1'b1) begin
      failures++;
      $display("[TB] FAIL quiet_state got led=%h buzz=%b active=%b want led=3ff buzz=0 active=1",
               led, buzz, active);
    end
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, 1'b1, (i == 0));
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL quiet_ack cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    checks++;
    if (led !== 10'h000 || buzz !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL quiet_ack_idle got led=%h buzz=%b active=%b want led=000 buzz=0 active=0",
               led, buzz, active);
    end
  endtask

  task automatic test_ack();
    logic [11:0] exp;
    // zero low, 6 cycles alarm, 8 cycles ack held, release, zero low,
    // then start and ack rising together, hold a while, exit.
    for (int i = 0; i < 26; i++) begin
      bit z;
      bit a;
      z = !(i == 0 || i == 15 || i == 25);
      a = (i >= 7 && i < 15) || (i >= 16 && i < 25);
      advance(z, 1'b1, a);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL ack cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
      if (i == 14) begin
        checks++;
        if (active !== 1'b0 || led !== 10'h000) begin
          failures++;
          $display("[TB] FAIL ack_held_idle got led=%h active=%b want led=000 active=0", led, active);
        end
      end
      if (i == 16) begin
        checks++;
        if (active !== 1'b1) begin
          failures++;
          $display("[TB] FAIL start_with_ack got active=%b want=1", active);
        end
      end
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [11:0] exp;
    int          n;
    bit          found;
    n     = 0;
    found = 1'b0;
    advance(1'b0, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    advance(1'b1, 1'b1, 1'b0);
    exp = sb_q.pop_front();
    checks++;
    if ({led, buzz, active} !== exp) begin
      failures++;
      $display("[TB] FAIL final_tick_entry got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
               led, buzz, active, exp[11:2], exp[1], exp[0]);
    end
    while (!found && n < 200) begin
      if (m_state == 1 && m_ticks == TO - 1 && m_div == TD - 1) begin
        found = 1'b1;
      end else begin
        advance(1'b1, 1'b1, 1'b0);
        exp = sb_q.pop_front();
        checks++;
        if ({led, buzz, active} !== exp) begin
          failures++;
          $display("[TB] FAIL final_tick_run cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                   n, led, buzz, active, exp[11:2], exp[1], exp[0]);
        end
        n++;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL final_tick_bound got cycles=%0d want final tick within 200", n);
    end else begin
      advance(1'b1, 1'b1, 1'b1);
      exp = sb_q.pop_front();
      checks++;
      if (active !== 1'b0 || {led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL final_tick_ack got led=%h buzz=%b active=%b want led=%h buzz=%b active=0",
                 led, buzz, active, exp[11:2], exp[1]);
      end
      advance(1'b1, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if (led !== 10'h000 || {led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL final_tick_idle got led=%h buzz=%b active=%b want led=000 buzz=0 active=0",
                 led, buzz, active);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    advance(1'b0, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      advance(1'b1, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL pre_reset cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (led !== 10'h000 || buzz !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got led=%h buzz=%b active=%b want led=000 buzz=0 active=0",
               led, buzz, active);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      advance(1'b1, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      checks++;
      if ({led, buzz, active} !== exp) begin
        failures++;
        $display("[TB] FAIL post_reset cyc%0d got led=%h buzz=%b active=%b want led=%h buzz=%b active=%b",
                 i, led, buzz, active, exp[11:2], exp[1], exp[0]);
      end
    end
    checks++;
    if (active !== 1'b0 || led !== 10'h000) begin
      failures++;
      $display("[TB] FAIL post_reset_idle got led=%h active=%b want led=000 active=0", led, active);
    end
  endtask

  initial begin
    $display("[TB] alarm_seq bench start");
    test_reset();
    test_no_arm();
    test_alarm_blink();
    test_timeout_quiet();
    test_ack();
    test_ack_at_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
